argmax_stream_sequencer: RTL and testbench
==========================================

// Module: argmax_stream_sequencer
// PURPOSE
// - Upstream driver for the rv32i_rtype_argmax accelerator.
// - Accepts a valid/ready stream of fp32 logits from the TPU output path, N beats per row.
// - Writes each row into the argmax logits memory with AM_XWR, then issues AM_START.
// - Waits for done, reads the results with AM_RIDX/AM_RMAX and emits one {row, idx, max} result per row.
// PARAMETERS
// - M       8   rows in logits memory; row counter wraps M-1 -> 0
// - N       8   logits per row (beats per row)
// - ROW_W   (M<=1)?1:$clog2(M)   row field width
// - COL_W   (N<=1)?1:$clog2(N)   col / index field width
// PORTS
// - clk             in   1      clock
// - rst             in   1      synchronous, active-high reset
// - en              in   1      run enable; sampled in IDLE only
// - s_valid         in   1      logit beat valid
// - s_ready         out  1      logit beat accepted when s_valid&&s_ready
// - s_data          in   32     fp32 logit bits
// - s_last          in   1      producer end-of-row marker; checked only
// - m_valid         out  1      result valid
// - m_ready         in   1      result consumed
// - m_row           out  ROW_W  row of result
// - m_idx           out  COL_W  argmax column
// - m_max           out  32     max value, fp32 bits
// - err_len         out  1      sticky: s_last disagreed with column count
// - rows_done       out  16     completed rows, wraps at 2^16
// - am_instr_valid  out  1      to argmax instr_valid
// - am_instr_ready  in   1      from argmax instr_ready
// - am_instr        out  32     R-type word: opcode 0x33, funct7 0x05, funct3 = cmd, rd = 5'd1, rs1 = rs2 = 0
// - am_rs1_val      out  32     XWR: {row,col} packed at [ROW_W+COL_W-1:0]; START: row at [ROW_W-1:0]
// - am_rs2_val      out  32     XWR data (= s_data); else 0
// - am_rd_addr      out  5      constant 5'd1
// - am_rd_we        in   1      argmax combinational read-back strobe
// - am_rd_wdata     in   32     argmax read-back data
// - am_busy         in   1      accel_busy
// - am_done         in   1      accel_done
// BEHAVIOUR
// - Reset: state IDLE; row=0, col=0; m_valid=0; m_row/m_idx/m_max=0; err_len=0; rows_done=0.
//   s_ready=0 and am_instr_valid=0 as a consequence of IDLE.
// - A reset mid-row discards the partial row. The core shares rst.
// - FSM states: IDLE, LOAD, START, WAIT, RIDX, RMAX, OUT.
// - IDLE: if en, go to LOAD.
// - LOAD: s_ready = am_instr_ready.
//   - Each accepted beat issues AM_XWR (funct3=000) in the same cycle with {row,col}; col++.
//   - The beat with col==N-1 resets col to 0 and goes to START.
//   - s_last is not used for framing. If s_last != (col==N-1) on an accepted beat, set err_len.
// - START: issue AM_START (001) for one cycle with rs1=row, then go to WAIT.
// - WAIT: no instruction. Leave when am_done=1.
//   - am_done is low in the first WAIT cycle because the core has just entered RUN, so a stale done from the previous row cannot be mis-seen.
// - RIDX: issue AM_RIDX (011). Capture m_idx <= am_rd_wdata[COL_W-1:0] when am_rd_we&&am_instr_ready; go to RMAX.
// - RMAX: issue AM_RMAX (100). Capture m_max <= am_rd_wdata; m_row <= row; m_valid <= 1; go to OUT.
// - Any instruction with am_instr_ready=0 is held, with identical fields, until accepted.
// - OUT: m_valid held with stable fields until m_ready.
//   - On m_valid&&m_ready: m_valid <= 0; rows_done++; row <= (row==M-1)?0:row+1.
//   - Next state is LOAD if en, else IDLE.
//   - No new logits are accepted in OUT. Backpressure propagates to s_ready.
// - Latency: if the last beat of a row is accepted in cycle t, START is at t+1 and the core is in RUN for t+2..t+N+1.
//   WAIT exits at t+N+2, RIDX at t+N+3, RMAX at t+N+4, and m_valid=1 from t+N+5. With N=8, that is 13 cycles.
// - am_instr_valid=0 in IDLE, WAIT and OUT. No XWR is ever issued while the core is busy.
// STRUCTURE
// - Shared package argmax_pkg: OPCODE_RTYPE=7'h33, FUNCT7_AM=7'h05, AM_XWR/START/STAT/RIDX/RMAX funct3 constants,
//   function am_encode(funct3) -> 32-bit instr, and the sequencer state_t enum.
// - Single module, no sub-modules. Instruction mux is combinational from state; all else registered.
// TESTING (bench instantiates this block + rv32i_rtype_argmax, M=N=8)
// - Row 0 = {1.0,2.0,-3.0,7.5,0.5,7.0,-0.0,6.0}, no stalls -> m_row=0, m_idx=3, m_max=32'h40F0_0000, m_valid at t+13.
// - All-negative row {-5,-1,-2,-9,-1,-3,-4,-8} -> m_idx=1 (first of equal max), m_max=32'hBF80_0000.
// - m_ready held low 20 cycles -> m_valid and fields stable, s_ready=0 throughout; release -> rows_done=1, next row accepted.
// - 9 rows back-to-back -> m_row sequence 0..7,0; rows_done=9; err_len=0.
// - s_last asserted on col 5 of a row -> err_len=1 and stays 1; row still completes with 8 beats.
// - rst asserted during WAIT -> next cycle m_valid=0, s_ready=0, row=0; following row result correct from row 0.

Source files
------------

// File: rtl/argmax_pkg.sv
// Shared constants, instruction encoder and sequencer state type for the
// rv32i_rtype_argmax accelerator and its stream sequencer.
package argmax_pkg;

    localparam logic [6:0] OPCODE_RTYPE = 7'h33;
    localparam logic [6:0] FUNCT7_AM    = 7'h05;
    localparam logic [4:0] AM_RD        = 5'd1;

    localparam logic [2:0] AM_XWR   = 3'b000;
    localparam logic [2:0] AM_START = 3'b001;
    localparam logic [2:0] AM_STAT  = 3'b010;
    localparam logic [2:0] AM_RIDX  = 3'b011;
    localparam logic [2:0] AM_RMAX  = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_RIDX,
        ST_RMAX,
        ST_OUT
    } state_t;

    // R-type word: funct7 | rs2 | rs1 | funct3 | rd | opcode
    function automatic logic [31:0] am_encode(input logic [2:0] funct3);
        return {FUNCT7_AM, 5'd0, 5'd0, funct3, AM_RD, OPCODE_RTYPE};
    endfunction

endpackage

// File: rtl/argmax_stream_sequencer.sv
// Streams fp32 logit rows into the argmax accelerator, starts it, reads back
// the index/max result and presents one {row, idx, max} result per row.
module argmax_stream_sequencer
    import argmax_pkg::*;
#(
    parameter int M     = 8,
    parameter int N     = 8,
    parameter int ROW_W = (M <= 1) ? 1 : $clog2(M),
    parameter int COL_W = (N <= 1) ? 1 : $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ROW_W-1:0] m_row,
    output logic [COL_W-1:0] m_idx,
    output logic [31:0]      m_max,
    output logic             err_len,
    output logic [15:0]      rows_done,
    output logic             am_instr_valid,
    input  logic             am_instr_ready,
    output logic [31:0]      am_instr,
    output logic [31:0]      am_rs1_val,
    output logic [31:0]      am_rs2_val,
    output logic [4:0]       am_rd_addr,
    input  logic             am_rd_we,
    input  logic [31:0]      am_rd_wdata,
    input  logic             am_busy,
    input  logic             am_done
);

    state_t           state;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             col_last;
    logic             beat;
    logic             rd_take;

    assign col_last   = (col == COL_W'(N - 1));
    // The busy term never masks a legal beat: the core is idle whenever LOAD is active.
    assign s_ready    = (state == ST_LOAD) && am_instr_ready && !am_busy;
    assign beat       = s_valid && s_ready;
    assign rd_take    = am_instr_ready && am_rd_we;
    assign am_rd_addr = AM_RD;

    // Instruction fields depend only on state and the held stream beat, so a
    // stalled instruction keeps identical fields until it is accepted.
    always_comb begin
        am_instr_valid = 1'b0;
        am_instr       = '0;
        am_rs1_val     = '0;
        am_rs2_val     = '0;
        case (state)
            ST_LOAD: begin
                am_instr_valid = s_valid && !am_busy;
                am_instr       = am_encode(AM_XWR);
                am_rs1_val     = 32'({row, col});
                am_rs2_val     = s_data;
            end
            ST_START: begin
                am_instr_valid = 1'b1;
                am_instr       = am_encode(AM_START);
                am_rs1_val     = 32'(row);
            end
            ST_RIDX: begin
                am_instr_valid = 1'b1;
                am_instr       = am_encode(AM_RIDX);
            end
            ST_RMAX: begin
                am_instr_valid = 1'b1;
                am_instr       = am_encode(AM_RMAX);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            row       <= '0;
            col       <= '0;
            m_valid   <= 1'b0;
            m_row     <= '0;
            m_idx     <= '0;
            m_max     <= '0;
            err_len   <= 1'b0;
            rows_done <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (beat) begin
                        // Framing comes from the column count; s_last is only audited.
                        if (s_last != col_last) err_len <= 1'b1;
                        if (col_last) begin
                            col   <= '0;
                            state <= ST_START;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    if (am_instr_ready) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (am_done) state <= ST_RIDX;
                end
                ST_RIDX: begin
                    if (rd_take) begin
                        m_idx <= am_rd_wdata[COL_W-1:0];
                        state <= ST_RMAX;
                    end
                end
                ST_RMAX: begin
                    if (rd_take) begin
                        m_max   <= am_rd_wdata;
                        m_row   <= row;
                        m_valid <= 1'b1;
                        state   <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (m_ready) begin
                        m_valid   <= 1'b0;
                        rows_done <= rows_done + 16'd1;
                        row       <= (row == ROW_W'(M - 1)) ? '0 : row + 1'b1;
                        state     <= en ? ST_LOAD : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_stream_sequencer.sv
// Bench for argmax_stream_sequencer with a behavioural argmax core alongside it;
// results are checked against an expected queue built from the driven rows.
module tb_argmax_stream_sequencer;

  localparam int M     = 8;
  localparam int N     = 8;
  localparam int ROW_W = 3;
  localparam int COL_W = 3;
  localparam int EW    = ROW_W + COL_W + 32;

  typedef logic [N-1:0][31:0] row_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic             rst, en, s_valid, s_last, m_ready;
  logic [31:0]      s_data;
  logic             s_ready, m_valid, err_len;
  logic [ROW_W-1:0] m_row;
  logic [COL_W-1:0] m_idx;
  logic [31:0]      m_max;
  logic [15:0]      rows_done;
  logic             am_instr_valid, am_rd_we, am_busy, am_done;
  logic [31:0]      am_instr, am_rs1_val, am_rs2_val, am_rd_wdata;
  logic [4:0]       am_rd_addr;
  logic             core_ready = 1'b1;
  logic             stall_en = 1'b0;

  argmax_stream_sequencer #(.M(M), .N(N)) dut (
    .clk(clk), .rst(rst), .en(en),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_row(m_row), .m_idx(m_idx), .m_max(m_max),
    .err_len(err_len), .rows_done(rows_done),
    .am_instr_valid(am_instr_valid), .am_instr_ready(core_ready), .am_instr(am_instr),
    .am_rs1_val(am_rs1_val), .am_rs2_val(am_rs2_val), .am_rd_addr(am_rd_addr),
    .am_rd_we(am_rd_we), .am_rd_wdata(am_rd_wdata), .am_busy(am_busy), .am_done(am_done)
  );

  // ---------------- scoreboard state ----------------
  int             n_vec = 0;
  int             n_err = 0;
  logic [EW-1:0]  exp_q[$];
  logic [ROW_W-1:0] exp_row = '0;
  logic [15:0]    rows_model = '0;
  int             t_last = 0;
  int             valid_cyc = 0;
  logic [ROW_W-1:0] got_row;
  logic [COL_W-1:0] got_idx;
  logic [31:0]    got_max;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference argmax ----------------
  // Map fp32 bits to an unsigned key whose order matches numeric order.
  function automatic logic [31:0] fkey(input logic [31:0] f);
    return f[31] ? ~f : (f | 32'h8000_0000);
  endfunction

  function automatic int ref_idx(input row_t d);
    int best = 0;
    for (int c = 1; c < N; c++)
      if (fkey(d[c]) > fkey(d[best])) best = c;
    return best;
  endfunction

  function automatic logic [31:0] ref_max(input row_t d);
    return d[ref_idx(d)];
  endfunction

  function automatic row_t gen_row();
    row_t d;
    for (int c = 0; c < N; c++)
      d[c] = {1'($urandom_range(0, 1)), 8'(120 + $urandom_range(0, 15)), 23'($urandom)};
    return d;
  endfunction

  // ---------------- behavioural argmax core ----------------
  row_t             mem[M];
  logic             core_busy = 1'b0;
  logic             core_done = 1'b0;
  int               run_cnt = 0;
  logic [ROW_W-1:0] run_row = '0;
  logic             take;

  assign take        = am_instr_valid && core_ready;
  assign am_busy     = core_busy;
  assign am_done     = core_done;
  assign am_rd_we    = take && (am_instr[14:12] == 3'b011 || am_instr[14:12] == 3'b100);
  assign am_rd_wdata = (am_instr[14:12] == 3'b011) ? 32'(ref_idx(mem[run_row])) : ref_max(mem[run_row]);

  always @(posedge clk) begin
    #1;
    core_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  always @(posedge clk) begin
    if (rst) begin
      core_busy <= 1'b0;
      core_done <= 1'b0;
      run_cnt   <= 0;
    end else begin
      if (core_busy) begin
        if (run_cnt == 1) begin
          core_busy <= 1'b0;
          core_done <= 1'b1;
        end
        run_cnt <= run_cnt - 1;
      end
      if (take) begin
        case (am_instr[14:12])
          3'b000: mem[am_rs1_val[5:3]][am_rs1_val[2:0]] <= am_rs2_val;
          3'b001: begin
            run_row   <= am_rs1_val[2:0];
            core_busy <= 1'b1;
            core_done <= 1'b0;
            run_cnt   <= N;
          end
          default: ;
        endcase
      end
    end
  end

  // Instruction word audit on every accepted instruction.
  always @(negedge clk) begin
    if (!rst && take) begin
      chk("instr_fixed", 32'({am_instr[31:15], am_instr[11:0]}), 32'({7'h05, 10'd0, 5'd1, 7'h33}));
      chk("rd_addr", 32'(am_rd_addr), 32'd1);
      if (am_instr[14:12] == 3'b000) chk("xwr_while_busy", 32'(am_busy), 32'd0);
      else chk("rs2_zero", am_rs2_val, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_row(input row_t d, input int last_pos, input bit gaps);
    int w;
    for (int c = 0; c < N; c++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      s_valid = 1'b1;
      s_data  = d[c];
      s_last  = (c == last_pos);
      w = 0;
      while (s_ready !== 1'b1 && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (s_ready !== 1'b1) begin
        chk("s_ready_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        return;
      end
      t_last = cyc;
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
    exp_q.push_back({exp_row, 3'(ref_idx(d)), ref_max(d)});
  endtask

  task automatic collect(input int hold);
    logic [EW-1:0] e;
    int k = 0;
    while (m_valid !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (m_valid !== 1'b1) begin
      chk("m_valid_timeout", 32'd0, 32'd1);
      return;
    end
    valid_cyc = cyc;
    if (exp_q.size() == 0) begin
      chk("unexpected_result", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      chk("hold_flags", 32'({m_valid, s_ready, m_row, m_idx}), 32'({1'b1, 1'b0, e[EW-1 -: ROW_W], e[31+COL_W -: COL_W]}));
      chk("hold_max", m_max, e[31:0]);
      @(negedge clk);
    end
    chk("m_row", 32'(m_row), 32'(e[EW-1 -: ROW_W]));
    chk("m_idx", 32'(m_idx), 32'(e[31+COL_W -: COL_W]));
    chk("m_max", m_max, e[31:0]);
    got_row = m_row;
    got_idx = m_idx;
    got_max = m_max;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    rows_model = rows_model + 16'd1;
    exp_row    = (exp_row == ROW_W'(M - 1)) ? '0 : exp_row + 1'b1;
    chk("m_valid_drop", 32'(m_valid), 32'd0);
    chk("rows_done", 32'(rows_done), 32'(rows_model));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    row_t r0, rneg;
    r0   = {32'h40C0_0000, 32'h8000_0000, 32'h40E0_0000, 32'h3F00_0000,
            32'h40F0_0000, 32'hC040_0000, 32'h4000_0000, 32'h3F80_0000};
    rneg = {32'hC100_0000, 32'hC080_0000, 32'hC040_0000, 32'hBF80_0000,
            32'hC110_0000, 32'hC000_0000, 32'hBF80_0000, 32'hC0A0_0000};
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_instr_valid", 32'(am_instr_valid), 32'd0);
    chk("rst_fields", 32'({m_row, m_idx}), 32'd0);
    chk("rst_m_max", m_max, 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
    chk("rst_rows_done", 32'(rows_done), 32'd0);
    en = 1'b1;

    // Directed row 0 with no stalls: fixed latency and known answer.
    send_row(r0, N - 1, 1'b0);
    collect(0);
    chk("row0_latency", 32'(valid_cyc - t_last), 32'd13);
    chk("row0_row", 32'(got_row), 32'd0);
    chk("row0_idx", 32'(got_idx), 32'd3);
    chk("row0_max", got_max, 32'h40F0_0000);

    // All-negative row with a tie for the maximum.
    send_row(rneg, N - 1, 1'b0);
    collect(0);
    chk("neg_idx", 32'(got_idx), 32'd1);
    chk("neg_max", got_max, 32'hBF80_0000);

    // Result held under backpressure for 20 cycles.
    send_row(gen_row(), N - 1, 1'b0);
    collect(20);

    // Reset while the core is running.
    send_row(gen_row(), N - 1, 1'b0);
    @(negedge clk);
    chk("wait_busy", 32'(am_busy), 32'd1);
    chk("wait_no_instr", 32'(am_instr_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    exp_row    = '0;
    rows_model = '0;
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
    chk("mid_rst_rows_done", 32'(rows_done), 32'd0);

    // Nine rows back-to-back with random gaps and core stalls.
    stall_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send_row(gen_row(), N - 1, 1'b1);
      collect($urandom_range(0, 3));
      chk("b2b_row", 32'(got_row), 32'(i % M));
    end
    stall_en = 1'b0;
    chk("b2b_rows_done", 32'(rows_done), 32'd9);
    chk("b2b_err_len", 32'(err_len), 32'd0);

    // Early s_last: flagged, but the row still completes on the column count.
    send_row(gen_row(), 5, 1'b0);
    collect(0);
    chk("len_err_set", 32'(err_len), 32'd1);
    send_row(gen_row(), N - 1, 1'b0);
    collect(0);
    chk("len_err_sticky", 32'(err_len), 32'd1);
    chk("final_rows_done", 32'(rows_done), 32'd11);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
